// File: rtl/wb_debug_bridge_if.sv
// rtl/wb_debug_bridge_if.sv - Wishbone B4 single-transaction bus bundle
//
// Purpose: groups the Wishbone signals between the debug bridge (master)
// and the arbiter/cross-bar port (slave).
// Signals:
//   adr[31:0]   address           master -> slave
//   dat_o[31:0] write data        master -> slave
//   we          write enable      master -> slave
//   cyc         bus cycle         master -> slave
//   stb         strobe            master -> slave
//   dat_i[31:0] read data         slave  -> master
//   ack         acknowledge       slave  -> master
interface wb_debug_bridge_if;
    logic [31:0] adr;
    logic [31:0] dat_o;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [31:0] dat_i;
    logic        ack;

    modport master (
        output adr, dat_o, we, cyc, stb,
        input  dat_i, ack
    );

    modport slave (
        input  adr, dat_o, we, cyc, stb,
        output dat_i, ack
    );
endinterface

// File: rtl/wb_debug_bridge.sv
// rtl/wb_debug_bridge.sv - UART byte-stream to Wishbone single-cycle debug master
//
// Purpose: decodes host frames from the UART receiver
//   write: 0x57 A3 A2 A1 A0 D3 D2 D1 D0  -> response 0x4B (OK) / 0x45 (ERR)
//   read : 0x52 A3 A2 A1 A0              -> response D3 D2 D1 D0 / 0x45
// and issues exactly one Wishbone transaction per frame, aborting it when
// ACK does not arrive within TIMEOUT strobe cycles.
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   bus       Wishbone master modport
//   rx_data   received byte, qualified by rx_valid
//   rx_valid  one-cycle strobe per received byte
//   tx_data   response byte
//   tx_valid  response byte available
//   tx_ready  transmitter accepts tx_data this cycle
//   busy      high whenever the bridge is not idle
module wb_debug_bridge #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    wb_debug_bridge_if.master         bus,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic                      busy
);

    localparam logic [7:0]  CMD_WRITE = 8'h57;
    localparam logic [7:0]  CMD_READ  = 8'h52;
    localparam logic [7:0]  RSP_OK    = 8'h4B;
    localparam logic [7:0]  RSP_ERR   = 8'h45;
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_BUS,
        S_RESP
    } state_t;

    state_t      state_q;
    logic [1:0]  cnt_q;
    logic [15:0] tmo_q;
    logic        we_q;
    logic        err_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;

    logic [31:0] bus_adr_q;
    logic [31:0] bus_dat_q;
    logic        bus_we_q;
    logic        bus_cyc_q;
    logic        bus_stb_q;
    logic [7:0]  tx_data_q;
    logic        tx_valid_q;
    logic        busy_q;

    // Response byte at the current index and at the following one; the
    // following one is preloaded on a transfer so that tx_valid stays high
    // across consecutive read-data bytes.
    logic [7:0]  resp_byte_d;
    logic [7:0]  resp_next_d;
    logic        resp_last_d;

    function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    always_comb begin
        resp_byte_d = sel_byte(data_q, cnt_q);
        resp_next_d = sel_byte(data_q, cnt_q + 2'd1);
        resp_last_d = (cnt_q == 2'd3);
        if (err_q) begin
            resp_byte_d = RSP_ERR;
            resp_last_d = 1'b1;
        end else if (we_q) begin
            resp_byte_d = RSP_OK;
            resp_last_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 2'd0;
            tmo_q      <= 16'd0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
            bus_adr_q  <= 32'd0;
            bus_dat_q  <= 32'd0;
            bus_we_q   <= 1'b0;
            bus_cyc_q  <= 1'b0;
            bus_stb_q  <= 1'b0;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rx_valid && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
                        we_q    <= (rx_data == CMD_WRITE);
                        data_q  <= 32'd0;
                        cnt_q   <= 2'd0;
                        state_q <= S_ADDR;
                        busy_q  <= 1'b1;
                    end
                end

                S_ADDR: begin
                    if (rx_valid) begin
                        addr_q <= {addr_q[23:0], rx_data};
                        cnt_q  <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            cnt_q <= 2'd0;
                            if (we_q) begin
                                state_q <= S_DATA;
                            end else begin
                                // Bus outputs launch on the edge that captures the last byte.
                                bus_adr_q <= {addr_q[23:0], rx_data};
                                bus_dat_q <= 32'd0;
                                bus_we_q  <= 1'b0;
                                bus_cyc_q <= 1'b1;
                                bus_stb_q <= 1'b1;
                                tmo_q     <= 16'd0;
                                state_q   <= S_BUS;
                            end
                        end
                    end
                end

                S_DATA: begin
                    if (rx_valid) begin
                        data_q <= {data_q[23:0], rx_data};
                        cnt_q  <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            cnt_q     <= 2'd0;
                            bus_adr_q <= addr_q;
                            bus_dat_q <= {data_q[23:0], rx_data};
                            bus_we_q  <= 1'b1;
                            bus_cyc_q <= 1'b1;
                            bus_stb_q <= 1'b1;
                            tmo_q     <= 16'd0;
                            state_q   <= S_BUS;
                        end
                    end
                end

                S_BUS: begin
                    // ACK is checked first so an ACK on the final timeout edge still counts as OK.
                    if (bus.ack || tmo_q == TMO_LAST) begin
                        err_q     <= !bus.ack;
                        if (bus.ack && !we_q) begin
                            data_q <= bus.dat_i;
                        end
                        bus_adr_q <= 32'd0;
                        bus_dat_q <= 32'd0;
                        bus_we_q  <= 1'b0;
                        bus_cyc_q <= 1'b0;
                        bus_stb_q <= 1'b0;
                        cnt_q     <= 2'd0;
                        state_q   <= S_RESP;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end

                S_RESP: begin
                    if (!tx_valid_q) begin
                        tx_data_q  <= resp_byte_d;
                        tx_valid_q <= 1'b1;
                    end else if (tx_ready) begin
                        if (resp_last_d) begin
                            tx_data_q  <= 8'd0;
                            tx_valid_q <= 1'b0;
                            cnt_q      <= 2'd0;
                            state_q    <= S_IDLE;
                            busy_q     <= 1'b0;
                        end else begin
                            tx_data_q <= resp_next_d;
                            cnt_q     <= cnt_q + 2'd1;
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.adr   = bus_adr_q;
    assign bus.dat_o = bus_dat_q;
    assign bus.we    = bus_we_q;
    assign bus.cyc   = bus_cyc_q;
    assign bus.stb   = bus_stb_q;
    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign busy      = busy_q;

endmodule
